// File: rtl/mdunit_seq_if.sv
// Request/result bundle between the execute stage and the mult/div unit.
// The pipeline is the master; the iterative unit is the slave.
interface mdunit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             multordiv;
  logic             is_signed;
  logic             clear;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             divzero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, multordiv, is_signed, clear, a, b,
    input  busy, done, divzero, hi, lo
  );

  modport slave (
    input  start, multordiv, is_signed, clear, a, b,
    output busy, done, divzero, hi, lo
  );
endinterface

// File: rtl/mdunit_seq.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle, then a single sign-fix cycle before the done pulse.
module mdunit_seq #(
  parameter int WIDTH = 32
) (
  input logic        clk,
  input logic        reset,
  mdunit_seq_if.slave md
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [WIDTH-1:0]   araw_q, araw_d;
  logic               mul_q, mul_d;
  logic               sgn_q, sgn_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dz_q, dz_d;

  logic               accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   sh;
  logic [WIDTH:0]     rem_t;
  logic [WIDTH-1:0]   quo_t;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Operand magnitudes for signed requests; raw values otherwise.
  always_comb begin
    mag_a = md.a;
    mag_b = md.b;
    if (md.is_signed && md.a[WIDTH-1]) mag_a = -md.a;
    if (md.is_signed && md.b[WIDTH-1]) mag_b = -md.b;
  end

  // Datapath step for each state plus accept/abort control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    araw_d  = araw_q;
    mul_d   = mul_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    sum     = '0;
    sh      = '0;
    rem_t   = '0;
    quo_t   = '0;
    prod    = '0;
    q_fix   = '0;
    r_fix   = '0;
    accept  = 1'b0;

    if (md.clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_DONE: state_d = S_IDLE;
        S_CALC: begin
          if (mul_q) begin
            sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                + (acc_q[0] ? {1'b0, opd_q} : '0);
            acc_d = {sum, acc_q[WIDTH-1:1]};
          end else begin
            sh    = {acc_q, 1'b0};
            rem_t = sh[2*WIDTH:WIDTH];
            quo_t = sh[WIDTH-1:0];
            if (rem_t >= {1'b0, opd_q}) begin
              rem_t    = rem_t - {1'b0, opd_q};
              quo_t[0] = 1'b1;
            end
            acc_d = {rem_t[WIDTH-1:0], quo_t};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          state_d = S_DONE;
          if (mul_q) begin
            prod = acc_q;
            if (sgn_q && (sa_q ^ sb_q)) prod = -acc_q;
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
            dz_d = 1'b0;
          end else if (bz_q) begin
            hi_d = araw_q;
            lo_d = '1;
            dz_d = 1'b1;
          end else begin
            q_fix = acc_q[WIDTH-1:0];
            r_fix = acc_q[2*WIDTH-1:WIDTH];
            if (sgn_q && (sa_q ^ sb_q)) q_fix = -acc_q[WIDTH-1:0];
            if (sgn_q && sa_q) r_fix = -acc_q[2*WIDTH-1:WIDTH];
            hi_d = r_fix;
            lo_d = q_fix;
            dz_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      accept = md.start
             && (state_q == S_IDLE || state_q == S_DONE);
      if (accept) begin
        state_d = S_CALC;
        cnt_d   = '0;
        mul_d   = md.multordiv;
        sgn_d   = md.is_signed;
        sa_d    = md.is_signed & md.a[WIDTH-1];
        sb_d    = md.is_signed & md.b[WIDTH-1];
        bz_d    = (md.b == '0);
        araw_d  = md.a;
        dz_d    = 1'b0;
        if (md.multordiv) begin
          acc_d = {{WIDTH{1'b0}}, mag_b};
          opd_d = mag_a;
        end else begin
          acc_d = {{WIDTH{1'b0}}, mag_a};
          opd_d = mag_b;
        end
      end
    end
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      araw_q  <= '0;
      mul_q   <= 1'b0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      araw_q  <= araw_d;
      mul_q   <= mul_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign md.busy    = (state_q == S_CALC) || (state_q == S_FIX);
  assign md.done    = (state_q == S_DONE);
  assign md.divzero = dz_q;
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;

endmodule

// File: tb/tb_mdunit_seq.sv
// Directed bench for mdunit_seq: multiply/divide results, latency,
// abort, ignored start, back-to-back accept and async reset.
module tb_mdunit_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   lat;
  int   bc;
  int   npulse;
  logic [31:0] hold_hi;
  logic [31:0] hold_lo;

  mdunit_seq_if #(.WIDTH(32)) bus ();

  mdunit_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for done starting at cycle k0 after accept; counts busy cycles.
  task automatic wait_done(input int k0, output int l, output int b);
    l = -1;
    b = 0;
    for (int k = k0; k < 100; k++) begin
      if (bus.done) begin
        l = k;
        break;
      end
      if (bus.busy) b++;
      tick();
    end
  endtask

  task automatic run_op(input logic m, input logic s,
                        input logic [31:0] x, input logic [31:0] y,
                        output int l, output int b);
    bus.multordiv = m;
    bus.is_signed = s;
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    wait_done(1, l, b);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.multordiv = 1'b0;
    bus.is_signed = 1'b0;
    bus.clear = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) tick();

    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dz", 32'(bus.divzero), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    chk("mulu_lat", 32'(lat), 32'd34);
    chk("mulu_busy", 32'(bc), 32'd33);
    chk("mulu_busy_at_done", 32'(bus.busy), 32'd0);
    chk("mulu_hi", bus.hi, 32'hFFFFFFFE);
    chk("mulu_lo", bus.lo, 32'h00000001);

    run_op(1'b1, 1'b1, 32'hFFFFFFFD, 32'd7, lat, bc);
    chk("muls_hi", bus.hi, 32'hFFFFFFFF);
    chk("muls_lo", bus.lo, 32'hFFFFFFEB);

    run_op(1'b1, 1'b0, 32'hFFFFFFFD, 32'd7, lat, bc);
    chk("mulu2_hi", bus.hi, 32'h00000006);
    chk("mulu2_lo", bus.lo, 32'hFFFFFFEB);

    run_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bc);
    chk("divs_lat", 32'(lat), 32'd34);
    chk("divs_lo", bus.lo, 32'hFFFFFFFD);
    chk("divs_hi", bus.hi, 32'hFFFFFFFF);

    run_op(1'b0, 1'b0, 32'd100, 32'd7, lat, bc);
    chk("divu_lo", bus.lo, 32'd14);
    chk("divu_hi", bus.hi, 32'd2);

    run_op(1'b0, 1'b1, 32'h12345678, 32'd0, lat, bc);
    chk("dz_done", 32'(bus.done), 32'd1);
    chk("dz_flag", 32'(bus.divzero), 32'd1);
    chk("dz_lo", bus.lo, 32'hFFFFFFFF);
    chk("dz_hi", bus.hi, 32'h12345678);

    run_op(1'b0, 1'b0, 32'd100, 32'd7, lat, bc);
    chk("dz_clr_flag", 32'(bus.divzero), 32'd0);
    chk("dz_clr_lo", bus.lo, 32'd14);

    run_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    chk("ovf_lo", bus.lo, 32'h80000000);
    chk("ovf_hi", bus.hi, 32'h00000000);
    chk("ovf_dz", 32'(bus.divzero), 32'd0);

    // Abort at cycle 10; prior result must survive.
    hold_hi = bus.hi;
    hold_lo = bus.lo;
    tick();
    bus.multordiv = 1'b1;
    bus.is_signed = 1'b0;
    bus.a = 32'd9;
    bus.b = 32'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("clr_busy_c10", 32'(bus.busy), 32'd1);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_busy_c11", 32'(bus.busy), 32'd0);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) npulse++;
      tick();
    end
    chk("clr_no_done", 32'(npulse), 32'd0);
    chk("clr_hi_hold", bus.hi, hold_hi);
    chk("clr_lo_hold", bus.lo, hold_lo);

    // Start mid-CALC must be ignored.
    bus.multordiv = 1'b1;
    bus.is_signed = 1'b0;
    bus.a = 32'd6;
    bus.b = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.multordiv = 1'b0;
    bus.a = 32'd100;
    bus.b = 32'd100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(6, lat, bc);
    chk("ign_lat", 32'(lat), 32'd34);
    chk("ign_lo", bus.lo, 32'd42);
    chk("ign_hi", bus.hi, 32'd0);

    // Start during the DONE cycle.
    run_op(1'b1, 1'b1, 32'hFFFFFFFE, 32'd5, lat, bc);
    chk("b2b_lat", 32'(lat), 32'd34);
    chk("b2b_lo", bus.lo, 32'hFFFFFFF6);
    chk("b2b_hi", bus.hi, 32'hFFFFFFFF);

    // Async reset in the middle of a divide.
    run_op(1'b0, 1'b0, 32'd100, 32'd7, lat, bc);
    bus.multordiv = 1'b0;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_hi", bus.hi, 32'd0);
    chk("arst_lo", bus.lo, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_op(1'b1, 1'b0, 32'd6, 32'd7, lat, bc);
    chk("arst_mul_lat", 32'(lat), 32'd34);
    chk("arst_mul_lo", bus.lo, 32'd42);
    chk("arst_mul_hi", bus.hi, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
